// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration loader.
// Holds the loader state encoding, the tile chain geometry and the serial CRC-16 step.
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } cfg_state_e;

    localparam int          TILE_CFG_BITS = 46;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    // MSB-first CRC-16 update absorbing one serial bit; no reflection, no final XOR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        data_bit,
                                               input logic [15:0] poly);
        return {crc[14:0], 1'b0} ^ (((crc[15] ^ data_bit) == 1'b1) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/cgra_config_loader_if.sv
// Valid/ready word stream feeding configuration words into the loader.
interface cgra_config_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input  word_ready);
    modport slave  (input  word_data, input  word_valid, output word_ready);
endinterface

// File: rtl/cfg_crc16_serial.sv
// One-bit-per-cycle CRC-16 accumulator; clr has priority over en.
module cfg_crc16_serial
    import cgra_cfg_pkg::*;
#(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        data_bit,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, data_bit, POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cgra_config_loader.sv
// Serialises configuration words LSB-first into the CGRA config chain and
// optionally re-reads the chain by rotation, comparing CRC-16 signatures.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int          CHAIN_LEN = 16 * TILE_CFG_BITS,
    parameter int          WORD_W    = 32,
    parameter logic [15:0] CRC_POLY  = 16'h1021
) (
    input  logic                 Config_Clock,
    input  logic                 Config_Reset,
    input  logic                 start,
    input  logic                 verify_en,
    input  logic                 abort,
    cgra_config_loader_if.slave  words,
    output logic                 cfg_bit_out,
    input  logic                 cfg_bit_in,
    output logic                 cfg_shift_en,
    output logic                 busy,
    output logic                 done,
    output logic                 verify_ok
);

    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int BUF_CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BUF_CNT_W-1:0] BUF_FULL = BUF_CNT_W'(WORD_W);
    localparam logic [BUF_CNT_W-1:0] BUF_ONE  = BUF_CNT_W'(1);

    cfg_state_e            state_q, state_d;
    logic                  verify_req_q, verify_req_d;
    logic [WORD_W-1:0]     buf_q, buf_d;
    logic [BUF_CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  verify_ok_q, verify_ok_d;

    logic        shift_load;
    logic        last_load_bit;
    logic        last_verify_bit;
    logic        word_ready_c;
    logic        accept;
    logic [15:0] crc_in;
    logic [15:0] crc_out;

    assign shift_load      = (state_q == LOAD) && (buf_cnt_q != '0);
    assign last_load_bit   = shift_load && (bit_cnt_q == LAST_BIT);
    assign last_verify_bit = (state_q == VERIFY) && (bit_cnt_q == LAST_BIT);

    // No word is taken once the final chain bit is leaving the buffer.
    assign word_ready_c = (state_q == LOAD) && !abort && !last_load_bit &&
                          ((buf_cnt_q == '0) || ((buf_cnt_q == BUF_ONE) && shift_load));
    assign accept       = word_ready_c && words.word_valid;

    assign words.word_ready = word_ready_c;
    assign cfg_shift_en     = shift_load || (state_q == VERIFY);
    assign cfg_bit_out      = (state_q == LOAD)   ? buf_q[0]   :
                              (state_q == VERIFY) ? cfg_bit_in : 1'b0;
    assign busy             = (state_q == LOAD) || (state_q == VERIFY);
    assign done             = (state_q == DONE);
    assign verify_ok        = verify_ok_q;

    always_comb begin
        state_d      = state_q;
        verify_req_d = verify_req_q;
        buf_d        = buf_q;
        buf_cnt_d    = buf_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        verify_ok_d  = verify_ok_q;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                buf_cnt_d = '0;
                if (start) begin
                    verify_req_d = verify_en;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (shift_load) begin
                    buf_d     = buf_q >> 1;
                    buf_cnt_d = buf_cnt_q - BUF_ONE;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (accept) begin
                    buf_d     = words.word_data;
                    buf_cnt_d = BUF_FULL;
                end
                // Tail bits of a partial last word are dropped here.
                if (last_load_bit) begin
                    buf_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = verify_req_q ? VERIFY : DONE;
                end
            end
            VERIFY: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_verify_bit) begin
                    bit_cnt_d   = '0;
                    verify_ok_d = (crc16_step(crc_out, cfg_bit_in, CRC_POLY) == crc_in);
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d      = IDLE;
            verify_req_d = 1'b0;
            buf_d        = '0;
            buf_cnt_d    = '0;
            bit_cnt_d    = '0;
            verify_ok_d  = 1'b0;
        end
    end

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            state_q      <= IDLE;
            verify_req_q <= 1'b0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            verify_ok_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            verify_req_q <= verify_req_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            verify_ok_q  <= verify_ok_d;
        end
    end

    cfg_crc16_serial #(.POLY(CRC_POLY)) u_crc_in (
        .clk      (Config_Clock),
        .rst_n    (Config_Reset),
        .en       (shift_load),
        .clr      (state_q == IDLE),
        .data_bit (buf_q[0]),
        .crc      (crc_in)
    );

    cfg_crc16_serial #(.POLY(CRC_POLY)) u_crc_out (
        .clk      (Config_Clock),
        .rst_n    (Config_Reset),
        .en       (state_q == VERIFY),
        .clr      (state_q == IDLE),
        .data_bit (cfg_bit_in),
        .crc      (crc_out)
    );

endmodule

// File: tb/tb_cgra_config_loader.sv
// Self-checking bench for cgra_config_loader with a 46-bit fabric chain model.
module tb_cgra_config_loader;

    localparam int CHAIN = 46;
    localparam int NV    = 18;

    typedef struct {
        logic        ven;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap_start;
        int          gap_len;
        int          flip_at;
        int          start_mid;
        int          exp_stalls;
        logic        exp_ok;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic verify_en = 1'b0;
    logic abort = 1'b0;
    logic cfg_bit_out, cfg_bit_in, cfg_shift_en, busy, done, verify_ok;

    logic [CHAIN-1:0] fab = '0;
    logic [CHAIN-1:0] flip_mask = '0;

    int checks = 0;
    int errors = 0;

    cgra_config_loader_if #(.WORD_W(32)) words_if ();

    cgra_config_loader #(.CHAIN_LEN(CHAIN), .WORD_W(32), .CRC_POLY(16'h1021)) dut (
        .Config_Clock (clk),
        .Config_Reset (rst_n),
        .start        (start),
        .verify_en    (verify_en),
        .abort        (abort),
        .words        (words_if),
        .cfg_bit_out  (cfg_bit_out),
        .cfg_bit_in   (cfg_bit_in),
        .cfg_shift_en (cfg_shift_en),
        .busy         (busy),
        .done         (done),
        .verify_ok    (verify_ok)
    );

    always #5 clk = ~clk;

    // Fabric: plain shift register, ConfigIn at bit 0, ConfigOut from the top bit.
    always @(posedge clk) begin
        fab <= (cfg_shift_en ? {fab[CHAIN-2:0], cfg_bit_out} : fab) ^ flip_mask;
    end
    assign cfg_bit_in = fab[CHAIN-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CHAIN-1:0] expectedChain(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0]      stream;
        logic [CHAIN-1:0] c;
        stream = {w1, w0};
        for (int k = 0; k < CHAIN; k++) c[CHAIN-1-k] = stream[k];
        return c;
    endfunction

    task automatic applyStimulus(input vec_t v);
        logic [31:0] wd [2];
        int widx = 0, shifts = 0, stalls = 0, rdy_n = 0, done_n = 0;
        int rdy_c [4];
        int first_shift = -1, last_shift = -1, done_cyc = -1;
        logic ok_at_done = 1'b0, busy_at_done = 1'b1;
        wd[0] = v.w0;
        wd[1] = v.w1;
        for (int i = 0; i < 4; i++) rdy_c[i] = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            flip_mask = '0;
            start     = (cyc == 0) || (v.start_mid != 0 && cyc == v.start_mid);
            verify_en = (cyc == 0) ? v.ven : !v.ven;
            words_if.word_valid = (widx < 2) && !(cyc >= v.gap_start && cyc < v.gap_start + v.gap_len);
            words_if.word_data  = words_if.word_valid ? wd[widx] : $urandom;
            #1;
            if (words_if.word_ready) begin
                if (rdy_n < 4) rdy_c[rdy_n] = cyc;
                rdy_n++;
                if (words_if.word_valid) widx++;
            end
            if (cfg_shift_en) begin
                shifts++;
                if (first_shift < 0) first_shift = cyc;
                last_shift = cyc;
                if (v.flip_at >= 0 && shifts - CHAIN - 1 == v.flip_at)
                    flip_mask = {1'b1, {(CHAIN-1){1'b0}}} >> 1;
            end
            if (busy && !cfg_shift_en) stalls++;
            if (done) begin
                done_n++;
                done_cyc     = cyc;
                ok_at_done   = verify_ok;
                busy_at_done = busy;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        @(negedge clk);
        flip_mask = '0;
        start = 1'b0;
        words_if.word_valid = 1'b0;
        checkOutput("shift_count", shifts, v.ven ? 2 * CHAIN : CHAIN);
        checkOutput("words_taken", widx, 2);
        checkOutput("done_count", done_n, 1);
        checkOutput("done_latency", done_cyc - last_shift, 1);
        checkOutput("busy_at_done", busy_at_done, 0);
        checkOutput("verify_ok", ok_at_done, v.exp_ok);
        if (v.exp_stalls >= 0) checkOutput("load_stalls", stalls, v.exp_stalls);
        if (v.gap_len == 0) begin
            checkOutput("ready_count", rdy_n, 2);
            checkOutput("ready_first", rdy_c[0], 1);
            checkOutput("ready_second", rdy_c[1], 33);
            checkOutput("shift_run", last_shift - first_shift + 1, shifts);
        end
        if (v.flip_at < 0) checkOutput("chain", fab, expectedChain(v.w0, v.w1));
    endtask

    function automatic vec_t mkVec(input logic ven, input logic [31:0] w0, input logic [31:0] w1,
                                   input int gs, input int gl, input int fl, input int sm,
                                   input int st, input logic ok);
        vec_t v;
        v.ven = ven; v.w0 = w0; v.w1 = w1; v.gap_start = gs; v.gap_len = gl;
        v.flip_at = fl; v.start_mid = sm; v.exp_stalls = st; v.exp_ok = ok;
        return v;
    endfunction

    vec_t vecs [NV];

    initial begin
        logic ok_model;
        int   sh;
        int   widx;
        logic [31:0] wd [2];

        vecs[0] = mkVec(1'b1, 32'hDEADBEEF, 32'h0000_3FFF, 1000, 0, -1, 0, 1, 1'b1);
        vecs[1] = mkVec(1'b0, 32'hDEADBEEF, 32'h0000_3FFF, 1000, 0, -1, 0, 1, 1'b1);
        vecs[2] = mkVec(1'b1, 32'hDEADBEEF, 32'h0000_3FFF, 1000, 0, 12, 0, 1, 1'b0);
        vecs[3] = mkVec(1'b0, 32'hDEADBEEF, 32'h0000_3FFF, 30, 5, -1, 0, 3, 1'b0);
        vecs[4] = mkVec(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 30, 5, -1, 0, 3, 1'b1);
        vecs[5] = mkVec(1'b0, 32'hA5A5_0F0F, 32'h0000_2AAA, 1000, 0, -1, 10, 1, 1'b1);
        ok_model = 1'b1;
        for (int i = 6; i < NV; i++) begin
            vecs[i].ven        = 1'($urandom_range(0, 1));
            vecs[i].w0         = $urandom;
            vecs[i].w1         = $urandom;
            vecs[i].gap_len    = $urandom_range(0, 6);
            vecs[i].gap_start  = $urandom_range(2, 45);
            vecs[i].flip_at    = (vecs[i].ven && $urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
            vecs[i].start_mid  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : 0;
            vecs[i].exp_stalls = (vecs[i].gap_len == 0) ? 1 : -1;
            if (vecs[i].ven) ok_model = (vecs[i].flip_at < 0);
            vecs[i].exp_ok     = ok_model;
        end

        words_if.word_valid = 1'b0;
        words_if.word_data  = '0;
        repeat (3) @(negedge clk);
        #1 checkOutput("reset_outputs", {cfg_bit_out, cfg_shift_en, busy, done, verify_ok, words_if.word_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkOutput("idle_outputs", {cfg_bit_out, cfg_shift_en, busy, done, verify_ok, words_if.word_ready}, 0);

        for (int i = 0; i < NV; i++) begin
            $display("[TB] vector %0d ven=%0d gap=%0d flip=%0d", i, vecs[i].ven, vecs[i].gap_len, vecs[i].flip_at);
            applyStimulus(vecs[i]);
        end

        // Abort at bit 20 of LOAD after a good verify left verify_ok set.
        applyStimulus(mkVec(1'b1, 32'hCAFE_F00D, 32'h0000_1555, 1000, 0, -1, 0, 1, 1'b1));
        wd[0] = 32'h0BAD_F00D;
        wd[1] = 32'h0000_0FFF;
        sh = 0;
        widx = 0;
        for (int cyc = 0; cyc < 100 && sh < 20; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            verify_en = 1'b1;
            words_if.word_valid = (widx < 2);
            words_if.word_data  = wd[widx % 2];
            #1;
            if (words_if.word_ready && words_if.word_valid) widx++;
            if (cfg_shift_en) sh++;
        end
        checkOutput("abort_reached_bit20", sh, 20);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        words_if.word_valid = 1'b1;
        #1 checkOutput("abort_outputs", {busy, done, verify_ok, words_if.word_ready, cfg_shift_en}, 0);
        sh = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1 if (done || busy) sh++;
        end
        checkOutput("abort_no_done", sh, 0);
        words_if.word_valid = 1'b0;
        applyStimulus(mkVec(1'b1, 32'h600D_C0DE, 32'h0000_2DB6, 1000, 0, -1, 0, 1, 1'b1));

        // Asynchronous reset in the middle of VERIFY.
        sh = 0;
        widx = 0;
        for (int cyc = 0; cyc < 200 && sh < CHAIN + 10; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            verify_en = 1'b1;
            words_if.word_valid = (widx < 2);
            words_if.word_data  = wd[widx % 2];
            #1;
            if (words_if.word_ready && words_if.word_valid) widx++;
            if (cfg_shift_en) sh++;
        end
        checkOutput("reached_verify", {busy, cfg_shift_en, verify_ok}, 3'b111);
        start = 1'b0;
        words_if.word_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", {cfg_bit_out, cfg_shift_en, busy, done, verify_ok, words_if.word_ready}, 0);
        @(negedge clk);
        #1 checkOutput("reset_held_outputs", {cfg_bit_out, cfg_shift_en, busy, done, verify_ok, words_if.word_ready}, 0);
        rst_n = 1'b1;
        applyStimulus(mkVec(1'b1, 32'h0F1E_2D3C, 32'h0000_1A2B, 1000, 0, -1, 0, 1, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgra_config_loader.md
Name: cgra_config_loader

Overview:
- Sequences the serial configuration chain of a CGRA fabric of tiles. Each tile's chain is Func 4b, MuxA 3b, MuxB 3b, MuxBypass 3b, MuxOut 1b and const 32b, 46 bits per tile.
- Accepts 32-bit configuration words over a valid/ready stream and serialises them LSB-first onto the fabric's ConfigIn.
- Emits a per-cycle shift enable that gates the fabric's config clock.
- Optionally verifies the loaded contents by rotating the chain once through itself and comparing CRC-16 signatures.

Parameters:
- CHAIN_LEN, 736, total chain bits (16 tiles x 46); must be >= 1.
- WORD_W, 32, width of an input configuration word.
- CRC_POLY, 16'h1021, CRC-16 generator polynomial; init value 16'hFFFF, no reflection, no final XOR.

Ports:
- Config_Clock  in  1  single clock for loader and fabric config cells.
- Config_Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE.
- verify_en  in  1  sampled with start; 1 = run VERIFY after LOAD.
- abort  in  1  forces return to IDLE on the next edge.
- word_data  in  WORD_W  configuration word; bit 0 is shifted first.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  loader accepts word_data this cycle.
- cfg_bit_out  out  1  drives fabric ConfigIn.
- cfg_bit_in  in  1  from fabric ConfigOut (last cell of the chain).
- cfg_shift_en  out  1  fabric config cells shift on this edge.
- busy  out  1  high in LOAD or VERIFY.
- done  out  1  one-cycle pulse at completion.
- verify_ok  out  1  result of the last verify; valid from done.

Behaviour:
- Reset: state IDLE; all outputs 0; bit counter, buffer count and both CRCs cleared (CRCs to 16'hFFFF).
- States are IDLE, LOAD, VERIFY and DONE.
- IDLE:
  - start=1 latches verify_en and goes to LOAD.
  - Clears bit_cnt and buf_cnt, and sets crc_in and crc_out to 16'hFFFF.
- LOAD, buffer:
  - 32-bit shift buffer plus buf_cnt (0..WORD_W).
  - word_ready = (buf_cnt==0) || (buf_cnt==1 && cfg_shift_en). This allows gapless streaming: one bit per cycle, one word every WORD_W cycles.
  - On valid&&ready the buffer loads word_data and buf_cnt becomes WORD_W.
  - The first bit of that word appears on cfg_bit_out with cfg_shift_en=1 in the next cycle.
- LOAD, shifting:
  - cfg_shift_en = (buf_cnt!=0); cfg_bit_out = buffer[0], combinational from registers.
  - Each shift cycle: buffer >>1, buf_cnt-1, bit_cnt+1, and crc_in updated with the bit.
  - Starved (buf_cnt==0): cfg_shift_en=0 and nothing advances; the fabric holds its state.
- LOAD, end of chain:
  - When bit_cnt reaches CHAIN_LEN, remaining buffer bits are discarded (buf_cnt forced to 0) and word_ready goes to 0.
  - Next state is VERIFY if verify_en was latched, else DONE.
  - A partial last word is legal, e.g. 736 = 23 words exactly; 46 bits = 2 words with 18 discarded.
- VERIFY:
  - Runs exactly CHAIN_LEN cycles with cfg_shift_en=1, cfg_bit_out=cfg_bit_in (rotation preserves contents) and word_ready=0.
  - crc_out is updated with cfg_bit_in each cycle. The chain is FIFO, so bits emerge in load order.
  - After CHAIN_LEN cycles, verify_ok <= (crc_out==crc_in), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - If verify was not requested, verify_ok is left unchanged.
- busy: high in LOAD and VERIFY.
- abort: highest priority in any state. Next state is IDLE; buffer and counters are cleared; done is not pulsed; verify_ok is cleared. Chain contents are then undefined.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- Counter widths:
  - bit_cnt is $clog2(CHAIN_LEN+1) bits with no wrap; the compare is against CHAIN_LEN-1 on a shift cycle.
  - The VERIFY counter reuses bit_cnt, reset on entry.
- Reset mid-operation: immediately returns all outputs to their reset values, asynchronously.

Decomposition:
- Shared package cgra_cfg_pkg holds:
  - state enum (IDLE, LOAD, VERIFY, DONE);
  - TILE_CFG_BITS=46;
  - CRC_INIT=16'hFFFF.
- One sub-module, cfg_crc16_serial: one-bit-per-cycle CRC with inputs en, clr, bit and output crc[15:0]. It is instantiated twice, for crc_in and crc_out.

Test Plan:
- CHAIN_LEN=46, verify_en=0, words 32'hDEADBEEF then 32'h0000_3FFF with valid held high:
  - word_ready high in cycles 1 and 33;
  - cfg_shift_en high for 46 consecutive cycles;
  - a 46-bit shadow chain model holds EF,BE,AD,DE then 14 ones;
  - done pulses once, 1 cycle after the last shift.
- Same load with verify_en=1 and the fabric modelled as a 46-bit shift register: VERIFY lasts 46 cycles, the chain is unchanged afterwards, and verify_ok=1 at done.
- Verify with one chain bit flipped by the bench mid-VERIFY -> verify_ok=0 at done.
- word_valid starvation, dropping valid for 5 cycles mid-word: cfg_shift_en=0 during the gap, bit_cnt frozen, final chain contents identical to the gapless case.
- abort asserted at bit 20 of LOAD -> IDLE next cycle, busy=0, no done, word_ready=0. A fresh start then loads correctly.
- Config_Reset pulsed low mid-VERIFY -> all outputs 0 asynchronously. start during LOAD is ignored, with no restart.
